// File: rtl/merger_feed_4.sv
// merger_feed_4: two-way merge of sorted 4x32 tuple streams via an external 8-input bitonic network; MERGER_FEED_COUNT_EN adds out_count.
// Latency: seed issue to first out_valid is 4 cycles; one tuple in flight through the 3-cycle network at a time.
// Backpressure: out_ready stalls the 4-entry FWFT output FIFO; no issue while it holds more than 2 tuples.

// fifo_sync: generic first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible on rd_vld/rd_dat the next cycle.
// Backpressure: wr_rdy low when full unless a pop happens in the same cycle.
module fifo_sync #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          wr_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    input  logic          rd_rdy,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign rd_vld  = (count != '0);
    assign rd_dat  = mem[rd_ptr];
    assign do_pop  = rd_vld && rd_rdy;
    assign wr_rdy  = (count != (AW+1)'(DEPTH)) || do_pop;
    assign do_push = wr_vld && wr_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module merger_feed_4 (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         a_valid,
    input  logic [127:0] a_data,
    input  logic         a_last,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [127:0] b_data,
    input  logic         b_last,
    output logic         b_ready,
    output logic [127:0] net_elems_0,
    output logic [127:0] net_elems_1,
    output logic         net_stall,
    output logic         net_switch_output,
    output logic [127:0] net_top_tuple,
    input  logic [127:0] net_o_elems_0,
    input  logic [127:0] net_o_elems_1,
    input  logic         net_o_stall,
    input  logic         net_o_switch_output,
`ifdef MERGER_FEED_COUNT_EN
    output logic [15:0]  out_count,
`endif
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);
    typedef enum logic [2:0] {IDLE, SEED, ISSUE, WAIT, FLUSH} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] fb_q;
    logic         a_done_q;
    logic         b_done_q;
    logic [2:0]   fifo_cnt;
    logic         res_vld;
    logic         room_issue;
    logic         room_flush;
    logic         sel_vld;
    logic         sel_a;
    logic         seed_go;
    logic         issue_go;
    logic         fb_ld;
    logic         push_vld;
    logic         push_last;
    logic [127:0] push_dat;
    logic         fifo_wr_rdy;
    logic         fifo_rd_vld;
    logic [128:0] fifo_rd_dat;

    assign res_vld       = !net_o_stall;
    assign room_issue    = (fifo_cnt <= 3'd2);
    assign room_flush    = (fifo_cnt <= 3'd3);
    assign net_top_tuple = '0;

    // Once a stream has delivered its last tuple only the other one is waited on.
    always_comb begin
        sel_vld = 1'b0;
        sel_a   = 1'b1;
        if (!a_done_q && !b_done_q) begin
            sel_vld = a_valid && b_valid;
            sel_a   = (a_data[31:0] <= b_data[31:0]);
        end else if (!a_done_q) begin
            sel_vld = a_valid;
            sel_a   = 1'b1;
        end else if (!b_done_q) begin
            sel_vld = b_valid;
            sel_a   = 1'b0;
        end
    end

    always_comb begin
        state_nxt         = state;
        net_stall         = 1'b1;
        net_switch_output = 1'b0;
        net_elems_0       = '0;
        net_elems_1       = '0;
        a_ready           = 1'b0;
        b_ready           = 1'b0;
        push_vld          = 1'b0;
        push_dat          = '0;
        push_last         = 1'b0;
        fb_ld             = 1'b0;
        seed_go           = 1'b0;
        issue_go          = 1'b0;
        case (state)
            IDLE: state_nxt = SEED;
            SEED: begin
                if (a_valid && b_valid && room_issue) begin
                    net_stall         = 1'b0;
                    net_switch_output = 1'b1;
                    net_elems_0       = a_data;
                    net_elems_1       = b_data;
                    a_ready           = 1'b1;
                    b_ready           = 1'b1;
                    seed_go           = 1'b1;
                    state_nxt         = WAIT;
                end
            end
            ISSUE: begin
                if (sel_vld && room_issue) begin
                    net_stall   = 1'b0;
                    net_elems_0 = sel_a ? a_data : b_data;
                    net_elems_1 = fb_q;
                    a_ready     = sel_a;
                    b_ready     = !sel_a;
                    issue_go    = 1'b1;
                    state_nxt   = WAIT;
                end
                // A stray seed result is stored but never steers the merge.
                if (res_vld && net_o_switch_output && fifo_wr_rdy) begin
                    push_vld = 1'b1;
                    push_dat = net_o_elems_0;
                end
            end
            WAIT: begin
                if (res_vld) begin
                    push_vld  = 1'b1;
                    push_dat  = net_o_elems_0;
                    fb_ld     = 1'b1;
                    state_nxt = (a_done_q && b_done_q) ? FLUSH : ISSUE;
                end
            end
            FLUSH: begin
                if (room_flush) begin
                    push_vld  = 1'b1;
                    push_dat  = fb_q;
                    push_last = 1'b1;
                    state_nxt = SEED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            fb_q     <= '0;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fb_ld) fb_q <= net_o_elems_1;
            if (seed_go) begin
                a_done_q <= a_last;
                b_done_q <= b_last;
            end else if (issue_go) begin
                if (sel_a) a_done_q <= a_last;
                else       b_done_q <= b_last;
            end
        end
    end

    fifo_sync #(
        .W  (129),
        .AW (2)
    ) u_out_fifo (
        .clk    (i_clk),
        .rst    (i_rst),
        .wr_vld (push_vld),
        .wr_dat ({push_last, push_dat}),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (fifo_rd_dat),
        .rd_rdy (out_ready),
        .count  (fifo_cnt)
    );

    assign out_valid = fifo_rd_vld;
    assign out_data  = fifo_rd_dat[127:0];
    assign out_last  = fifo_rd_dat[128] && fifo_rd_vld;

`ifdef MERGER_FEED_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            count_q <= '0;
        else if (push_vld && fifo_wr_rdy)
            count_q <= push_last ? 16'd0 : count_q + 16'd1;
    end

    assign out_count = count_q;
`endif
endmodule

// File: tb/tb_merger_feed_4.sv
// Bench for merger_feed_4: models the 3-cycle sorting network and checks every merge against a fully sorted reference.
module tb_merger_feed_4;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         a_valid, a_last, a_ready;
    logic         b_valid, b_last, b_ready;
    logic [127:0] a_data, b_data;
    logic [127:0] net_elems_0, net_elems_1, net_top_tuple;
    logic         net_stall, net_switch_output;
    logic [127:0] net_o_elems_0, net_o_elems_1;
    logic         net_o_stall, net_o_switch_output;
    logic         out_valid, out_last, out_ready;
    logic [127:0] out_data;
`ifdef MERGER_FEED_COUNT_EN
    logic [15:0]  out_count;
`endif

    merger_feed_4 dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .net_elems_0(net_elems_0), .net_elems_1(net_elems_1), .net_stall(net_stall),
        .net_switch_output(net_switch_output), .net_top_tuple(net_top_tuple),
        .net_o_elems_0(net_o_elems_0), .net_o_elems_1(net_o_elems_1),
        .net_o_stall(net_o_stall), .net_o_switch_output(net_o_switch_output),
`ifdef MERGER_FEED_COUNT_EN
        .out_count(out_count),
`endif
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    always #5 i_clk = ~i_clk;

    // Network model: sorts all 8 inputs, result appears 3 cycles after the issue cycle.
    function automatic logic [255:0] net_sort(input logic [127:0] x0, input logic [127:0] x1);
        logic [31:0]  v [8];
        logic [31:0]  t;
        logic [255:0] r;
        for (int i = 0; i < 4; i++) begin
            v[i]   = x0[32*i +: 32];
            v[i+4] = x1[32*i +: 32];
        end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = v[i];
        return r;
    endfunction

    logic [2:0]   pv = 3'b000;
    logic [2:0]   ps = 3'b000;
    logic [255:0] pd [3];

    always @(posedge i_clk) begin
        pv    <= {pv[1:0], !net_stall};
        ps    <= {ps[1:0], net_switch_output};
        pd[0] <= net_sort(net_elems_0, net_elems_1);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end

    assign net_o_stall         = !pv[2];
    assign net_o_switch_output = ps[2];
    assign net_o_elems_0       = pd[2][127:0];
    assign net_o_elems_1       = pd[2][255:128];

    logic [127:0] aq [$];
    logic [127:0] bq [$];
    logic [128:0] expq [$];
    logic [128:0] obs [$];
    int           sel_log [$];
    int           ai, bi, cyc, first_issue, first_out;
    int           total = 0;
    int           bad = 0;
    bit           bubbles;
    int           rdy_mode;

    function automatic logic [127:0] mk(input int unsigned e0, input int unsigned e1,
                                        input int unsigned e2, input int unsigned e3);
        return {e3[31:0], e2[31:0], e1[31:0], e0[31:0]};
    endfunction

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event, want none (cycle %0d)", name, cyc);
    endtask

    // Reference: every element of both streams, sorted, cut into tuples, last on the final one.
    task automatic prep();
        int unsigned vals [$];
        int unsigned t;
        int          nt;
        expq.delete(); obs.delete(); sel_log.delete();
        ai = 0; bi = 0; first_issue = -1; first_out = -1;
        foreach (aq[i]) for (int k = 0; k < 4; k++) vals.push_back(aq[i][32*k +: 32]);
        foreach (bq[i]) for (int k = 0; k < 4; k++) vals.push_back(bq[i][32*k +: 32]);
        for (int i = 1; i < vals.size(); i++)
            for (int j = i; j > 0 && vals[j-1] > vals[j]; j--) begin
                t = vals[j]; vals[j] = vals[j-1]; vals[j-1] = t;
            end
        nt = vals.size() / 4;
        for (int i = 0; i < nt; i++)
            expq.push_back({(i == nt - 1), mk(vals[4*i], vals[4*i+1], vals[4*i+2], vals[4*i+3])});
    endtask

    task automatic gen(input int na, input int nb);
        int unsigned  va, vb;
        logic [127:0] x;
        aq.delete(); bq.delete();
        va = $urandom_range(0, 8);
        vb = $urandom_range(0, 8);
        for (int t = 0; t < na; t++) begin
            for (int k = 0; k < 4; k++) begin va += $urandom_range(0, 3); x[32*k +: 32] = va; end
            aq.push_back(x);
        end
        for (int t = 0; t < nb; t++) begin
            for (int k = 0; k < 4; k++) begin vb += $urandom_range(0, 3); x[32*k +: 32] = vb; end
            bq.push_back(x);
        end
    endtask

    task automatic drive();
        a_valid   = (ai < aq.size()) && (!bubbles || $urandom_range(0, 3) != 0);
        a_data    = (ai < aq.size()) ? aq[ai] : '0;
        a_last    = (ai == aq.size() - 1);
        b_valid   = (bi < bq.size()) && (!bubbles || $urandom_range(0, 3) != 0);
        b_data    = (bi < bq.size()) ? bq[bi] : '0;
        b_last    = (bi == bq.size() - 1);
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic monitor();
        logic         exp_a;
        logic [128:0] e;
        cyc++;
        chk_i("stall_vs_ready", int'(net_stall), int'(!(a_ready || b_ready)));
        chk_i("switch_output", int'(net_switch_output), int'(a_ready && b_ready));
        chk("top_tuple", {1'b0, net_top_tuple}, '0);
        if (!net_stall && first_issue < 0) first_issue = cyc;
        if (a_ready && b_ready) begin
            sel_log.push_back(0);
            chk_i("seed_at_head", ai + bi, 0);
            if (aq.size() > 0 && bq.size() > 0) begin
                chk("seed_elems_0", {1'b0, net_elems_0}, {1'b0, aq[0]});
                chk("seed_elems_1", {1'b0, net_elems_1}, {1'b0, bq[0]});
            end
            ai++; bi++;
        end else if (a_ready || b_ready) begin
            sel_log.push_back(a_ready ? 1 : 2);
            if (ai < aq.size() && bi < bq.size()) exp_a = (aq[ai][31:0] <= bq[bi][31:0]);
            else exp_a = (ai < aq.size());
            chk_i("select_a", int'(a_ready), int'(exp_a));
            if (a_ready) begin
                chk_i("ready_without_valid", int'(a_valid), 1);
                if (ai < aq.size()) begin
                    chk("issue_elems_0", {1'b0, net_elems_0}, {1'b0, aq[ai]});
                    ai++;
                end else fail_now("a_overrun");
            end else begin
                chk_i("ready_without_valid", int'(b_valid), 1);
                if (bi < bq.size()) begin
                    chk("issue_elems_0", {1'b0, net_elems_0}, {1'b0, bq[bi]});
                    bi++;
                end else fail_now("b_overrun");
            end
        end
        if (out_valid && first_out < 0) first_out = cyc;
        if (!out_valid) chk_i("last_when_empty", int'(out_last), 0);
        if (out_valid && out_ready) begin
            obs.push_back({out_last, out_data});
            if (expq.size() == 0) fail_now("unexpected_out");
            else begin
                e = expq.pop_front();
                chk("out_tuple", {out_last, out_data}, e);
            end
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        drive();
        @(negedge i_clk);
        monitor();
    endtask

    task automatic do_reset();
        aq.delete(); bq.delete(); expq.delete();
        ai = 0; bi = 0;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = '0; b_data = '0; out_ready = 1'b1;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (6) step();
    endtask

    task automatic finish_merge();
        int n = 0;
        while ((expq.size() != 0 || ai < aq.size() || bi < bq.size()) && n < 800) begin
            step();
            n++;
        end
        if (n >= 800) begin
            fail_now("merge_timeout");
            do_reset();
        end
    endtask

    initial begin
        bubbles = 0; rdy_mode = 0; cyc = 0;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = '0; b_data = '0; out_ready = 1'b1;
        #1 i_rst = 1'b1;
        #1;
        chk_i("rst_net_stall", int'(net_stall), 1);
        chk_i("rst_a_ready", int'(a_ready), 0);
        chk_i("rst_b_ready", int'(b_ready), 0);
        chk_i("rst_out_valid", int'(out_valid), 0);
        chk_i("rst_out_last", int'(out_last), 0);
        chk_i("rst_switch", int'(net_switch_output), 0);
        chk("rst_elems_0", {1'b0, net_elems_0}, '0);
        chk("rst_elems_1", {1'b0, net_elems_1}, '0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) step();

        // Seed-only merge with hand-computed result and latency.
        aq = {mk(1, 3, 5, 7)};
        bq = {mk(2, 4, 6, 8)};
        prep();
        finish_merge();
        chk_i("seed_nout", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("seed_out0", obs[0], {1'b0, mk(1, 2, 3, 4)});
            chk("seed_out1", obs[1], {1'b1, mk(5, 6, 7, 8)});
        end
        chk_i("seed_latency", first_out - first_issue, 4);

        // Equal heads after the seed: A wins.
        aq = {mk(1, 2, 3, 4), mk(5, 6, 7, 8)};
        bq = {mk(1, 2, 3, 4), mk(5, 9, 9, 9)};
        prep();
        finish_merge();
        chk_i("tie_nsel", sel_log.size(), 3);
        if (sel_log.size() == 3) chk_i("tie_sel", sel_log[1], 1);
        chk_i("tie_nout", obs.size(), 4);
        if (obs.size() == 4) chk("tie_out2", obs[2], {1'b0, mk(5, 5, 6, 7)});

        // A exhausted at the seed: only B is consumed afterwards.
        aq = {mk(1, 2, 3, 4)};
        bq = {mk(5, 6, 7, 8), mk(9, 10, 11, 12), mk(13, 14, 15, 16)};
        prep();
        finish_merge();
        chk_i("exh_nsel", sel_log.size(), 3);
        if (sel_log.size() == 3) begin
            chk_i("exh_sel1", sel_log[1], 2);
            chk_i("exh_sel2", sel_log[2], 2);
        end
        chk_i("exh_nout", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("exh_out0", obs[0], {1'b0, mk(1, 2, 3, 4)});
            chk("exh_out3", obs[3], {1'b1, mk(13, 14, 15, 16)});
        end

        // Output held off: issuing stops once three results are buffered.
        gen(4, 4);
        prep();
        rdy_mode = 2;
        repeat (20) step();
        chk_i("bp_consumed", ai + bi, 4);
        chk_i("bp_out_valid", int'(out_valid), 1);
        rdy_mode = 0;
        finish_merge();
        chk_i("bp_nout", obs.size(), 8);

        // Reset while a result is in flight; FIFO holds one tuple at that moment.
        gen(3, 3);
        prep();
        rdy_mode = 2;
        begin
            int n = 0;
            while (sel_log.size() < 2 && n < 50) begin step(); n++; end
        end
        chk_i("rstw_issued", sel_log.size(), 2);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk_i("rstw_net_stall", int'(net_stall), 1);
        chk_i("rstw_a_ready", int'(a_ready), 0);
        chk_i("rstw_b_ready", int'(b_ready), 0);
        chk_i("rstw_out_valid", int'(out_valid), 0);
        chk_i("rstw_out_last", int'(out_last), 0);
        chk_i("rstw_switch", int'(net_switch_output), 0);
        chk("rstw_elems_0", {1'b0, net_elems_0}, '0);
        aq.delete(); bq.delete(); expq.delete();
        ai = 0; bi = 0; rdy_mode = 0;
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) step();
        gen(2, 3);
        prep();
        finish_merge();
        chk_i("rstw_next_nout", obs.size(), 5);

        // Randomized merges with input bubbles and random output stalls.
        bubbles = 1;
        rdy_mode = 1;
        for (int m = 0; m < 30; m++) begin
            gen(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            prep();
            finish_merge();
        end
        rdy_mode = 0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/merger_feed_4.md
MERGER_FEED_4 -- requirements
Module: merger_feed_4

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports a_valid/b_valid (in, 1), a_data/b_data (in, 128), a_last/b_last (in, 1), a_ready/b_ready (out, 1): two ascending-sorted input tuple streams, 4 x 32-bit unsigned, element 0 at [31:0].
REQ-004 SHALL have ports net_elems_0, net_elems_1 (out, 128), net_stall (out, 1), net_switch_output (out, 1), net_top_tuple (out, 128): drive the 8-input bitonic merge network.
REQ-005 SHALL have ports net_o_elems_0, net_o_elems_1 (in, 128), net_o_stall (in, 1), net_o_switch_output (in, 1): network results; net_o_elems_0 is the low 4, net_o_elems_1 the high 4, both ascending.
REQ-006 SHALL have ports out_valid (out, 1), out_data (out, 128), out_last (out, 1), out_ready (in, 1): merged output stream.

Function
REQ-007 SHALL treat a tuple as transferred on a stream when valid and ready are both 1 on a rising edge; ready pulses only on issue cycles.
REQ-008 SHALL drive net_stall = 0 only on issue cycles and 1 otherwise; net_top_tuple = 0 constant.
REQ-009 SHALL treat a network result as valid on any cycle with net_o_stall = 0; result arrives exactly 3 cycles after the issuing cycle.
REQ-010 SHALL implement states IDLE, SEED, ISSUE, WAIT, FLUSH; IDLE -> SEED unconditionally the cycle after reset release.
REQ-011 SEED: when a_valid, b_valid and FIFO count <= 2, SHALL issue a_data on net_elems_0, b_data on net_elems_1, net_switch_output = 1, assert a_ready and b_ready, record each stream's last flag as exhausted, go WAIT.
REQ-012 WAIT: on valid result SHALL push net_o_elems_0 into the output FIFO, load net_o_elems_1 into the feedback register, then go FLUSH if both streams exhausted, else ISSUE.
REQ-013 ISSUE: if neither stream exhausted, SHALL wait for both valid, select A when a_data[31:0] <= b_data[31:0] (ties to A), else B; if one exhausted, SHALL wait for the other's valid only.
REQ-014 ISSUE: when selection valid and FIFO count <= 2, SHALL issue selected data on net_elems_0, feedback on net_elems_1, net_switch_output = 0, assert only the selected ready, update its exhausted flag from its last, go WAIT.
REQ-015 FLUSH: when FIFO count <= 3, SHALL push the feedback tuple with out_last = 1 and go SEED; all other pushed tuples carry out_last = 0.
REQ-016 Output FIFO SHALL be 4 entries, first-word fall-through; out_valid = not empty; pop on out_valid & out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-017 A result arriving with net_o_switch_output = 1 outside WAIT-after-SEED SHALL be ignored for state but still pushed (protocol error is not checked).
REQ-018 Each input stream SHALL carry at least one tuple per merge; a 0-length stream is unsupported.

Reset
REQ-019 On i_rst = 1, SHALL immediately set state IDLE, FIFO empty, count 0, feedback 0, exhausted flags 0, net_stall = 1, a_ready = b_ready = 0, out_valid = 0, out_last = 0, net_switch_output = 0, net_elems_* = 0.
REQ-020 Reset mid-merge SHALL discard in-flight network results: results with net_o_stall = 0 arriving in IDLE or SEED SHALL be dropped.

Configuration
REQ-021 With MERGER_FEED_COUNT_EN defined, SHALL add output out_count (16 bits): tuples pushed in the current merge, cleared on the FLUSH push and at reset, wrapping at 65535 -> 0; without it the port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-022 Seed only: A={1,3,5,7} last, B={2,4,6,8} last -> out {1,2,3,4} then {5,6,7,8} with out_last=1; first issue to first out_valid = 4 cycles.
REQ-023 Tie: A heads {5,..} and B heads {5,..} after seed -> A selected, only a_ready pulses.
REQ-024 Exhaustion: A 1 tuple {1,2,3,4}, B 3 tuples {5..8},{9..12},{13..16} -> out 1..16 ascending in 4 tuples, last on final, only b_ready after seed.
REQ-025 Backpressure: out_ready = 0 for 20 cycles -> FIFO holds 3 data tuples, no issue while count > 2, no loss; release drains in order.
REQ-026 Reset asserted in WAIT -> outputs reach reset values same cycle; late network result dropped; next merge correct.
